// File: rtl/serializer_pkg.sv
// Shared definitions for par_serializer: FSM state type, frame length and
// bit-counter width helpers. Honours the SERIALIZER_PARITY_EN macro: when
// defined, every frame carries one extra even-parity bit after the data bits.
package serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Number of serial bits per frame for a given word width.
   function automatic int frame_len(input int data_w);
`ifdef SERIALIZER_PARITY_EN
      return data_w + 1;
`else
      return data_w;
`endif
   endfunction

   // Bit-counter width. Sized for a maximum count of data_w, which covers
   // FRAME_LEN-1 with or without the parity bit.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/par_serializer.sv
// par_serializer: parallel-to-serial converter. Accepts a DATA_W-bit word on a
// valid/ready handshake and shifts it out one bit per clock, MSB-first or
// LSB-first. Back-to-back frames run without a gap because a new word can be
// accepted on the final bit of the current frame.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of the accepted word) after the data bits; ser_last_o then marks it.
module par_serializer #(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_val_i,
   output logic              data_rdy_o,
   output logic              ser_data_o,
   output logic              ser_val_o,
   output logic              ser_last_o,
   output logic              busy_o
);

   import serializer_pkg::*;

   localparam int FRAME_LEN = frame_len(DATA_W);
   localparam int CNT_W     = cnt_width(DATA_W);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ser_state_t        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ser_data_q, ser_data_d;
   logic              ser_val_q, ser_val_d;
   logic              ser_last_q, ser_last_d;
   logic              accept;
`ifdef SERIALIZER_PARITY_EN
   logic              par_q, par_d;
`endif

   // Bit that leaves the word first in the configured bit order.
   function automatic logic lead_bit(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0) begin
         return w[DATA_W-1];
      end
      return w[0];
   endfunction

   // Word after removing the lead bit; the vacated end fills with zero.
   function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0) begin
         return w << 1;
      end
      return w >> 1;
   endfunction

   // Ready in IDLE or on the final bit of a frame; never during reset and
   // never a function of data_val_i.
   always_comb begin
      data_rdy_o = 1'b0;
      if (!rst_i) begin
         data_rdy_o = (state_q == IDLE) || (cnt_q == CNT_ZERO);
      end
      accept = data_val_i && data_rdy_o;
   end

   // Next-state, shift register, bit counter and registered serial outputs.
   // The serial output flops take the bit that will be on the wire next cycle,
   // so a word accepted at edge N shows its first bit right after edge N.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      ser_data_d = 1'b0;
      ser_val_d  = 1'b0;
      ser_last_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d      = par_q;
`endif

      if (accept) begin
         // New frame: lead bit goes straight to the output, rest waits in shreg.
         state_d    = SHIFT;
         shreg_d    = shift_word(data_i);
         cnt_d      = CNT_LOAD;
         ser_data_d = lead_bit(data_i);
         ser_val_d  = 1'b1;
         ser_last_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_d      = ^data_i;
`endif
      end else if (state_q == SHIFT) begin
         if (cnt_q == CNT_ZERO) begin
            // Final bit already on the wire and no follow-on word.
            state_d = IDLE;
         end else begin
            shreg_d    = shift_word(shreg_q);
            cnt_d      = cnt_q - CNT_ONE;
            ser_data_d = lead_bit(shreg_q);
            ser_val_d  = 1'b1;
            ser_last_d = (cnt_q == CNT_ONE);
`ifdef SERIALIZER_PARITY_EN
            // Data bits are exhausted when the stored parity bit is due.
            if (cnt_q == CNT_ONE) begin
               ser_data_d = par_q;
            end
`endif
         end
      end
   end

   // State and datapath registers; reset abandons any frame in progress.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         ser_data_q <= 1'b0;
         ser_val_q  <= 1'b0;
         ser_last_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         ser_data_q <= ser_data_d;
         ser_val_q  <= ser_val_d;
         ser_last_q <= ser_last_d;
`ifdef SERIALIZER_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign ser_data_o = ser_data_q;
   assign ser_val_o  = ser_val_q;
   assign ser_last_o = ser_last_q;
   assign busy_o     = ser_val_q;

endmodule

// File: tb/tb_par_serializer.sv
// Directed bench for par_serializer: three instances (6-bit MSB-first,
// 6-bit LSB-first, 8-bit MSB-first) sharing clock and reset.
module tb_par_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int FL6 = 7;
   localparam int FL8 = 9;
`else
   localparam int FL6 = 6;
   localparam int FL8 = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] d6;
   logic       v6;
   logic       rdy_m6, sd_m6, sv_m6, sl_m6, bz_m6;
   logic       rdy_l6, sd_l6, sv_l6, sl_l6, bz_l6;
   logic [7:0] d8;
   logic       v8;
   logic       rdy8, sd8, sv8, sl8, bz8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   par_serializer #(.DATA_W(6), .MSB_FIRST(1)) u_m6 (
      .clk_i(clk), .rst_i(rst), .data_i(d6), .data_val_i(v6),
      .data_rdy_o(rdy_m6), .ser_data_o(sd_m6), .ser_val_o(sv_m6),
      .ser_last_o(sl_m6), .busy_o(bz_m6));

   par_serializer #(.DATA_W(6), .MSB_FIRST(0)) u_l6 (
      .clk_i(clk), .rst_i(rst), .data_i(d6), .data_val_i(v6),
      .data_rdy_o(rdy_l6), .ser_data_o(sd_l6), .ser_val_o(sv_l6),
      .ser_last_o(sl_l6), .busy_o(bz_l6));

   par_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_m8 (
      .clk_i(clk), .rst_i(rst), .data_i(d8), .data_val_i(v8),
      .data_rdy_o(rdy8), .ser_data_o(sd8), .ser_val_o(sv8),
      .ser_last_o(sl8), .busy_o(bz8));

   typedef struct packed {
      logic [5:0] word;
      logic [5:0] msb_seq;  // transmission order, leftmost bit first
      logic [5:0] lsb_seq;  // transmission order, leftmost bit first
      logic       par;      // even parity of word
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected 8-bit MSB-first frame bit b of word w (parity bit after data).
   function automatic logic exp8(input logic [7:0] w, input int b);
      if (b < 8) return w[7-b];
      return ^w;
   endfunction

   // Upstream must hold data_i stable while waiting for ready.
   logic       pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = '0;
   always @(negedge clk) begin
      if (!rst && pv && !pr && v8) begin
         checks++;
         if (d8 !== pd) begin
            errors++;
            $display("FAIL stall_hold: data_i got %0h expected %0h", d8, pd);
         end
      end
      pv <= v8;
      pr <= rdy8;
      pd <= d8;
   end

   initial begin
      logic e;
      vecs[0] = '{word: 6'b101100, msb_seq: 6'b101100, lsb_seq: 6'b001101, par: 1'b1};
      vecs[1] = '{word: 6'b000001, msb_seq: 6'b000001, lsb_seq: 6'b100000, par: 1'b1};
      vecs[2] = '{word: 6'b111111, msb_seq: 6'b111111, lsb_seq: 6'b111111, par: 1'b0};
      vecs[3] = '{word: 6'b100110, msb_seq: 6'b100110, lsb_seq: 6'b011001, par: 1'b1};
      vecs[4] = '{word: 6'b010101, msb_seq: 6'b010101, lsb_seq: 6'b101010, par: 1'b1};
      vecs[5] = '{word: 6'b000000, msb_seq: 6'b000000, lsb_seq: 6'b000000, par: 1'b0};

      rst = 1'b1; d6 = '0; v6 = 1'b0; d8 = '0; v8 = 1'b0;
      tick(); tick();
      // Reset state
      chk("rst_sv_m6", sv_m6, 0); chk("rst_sd_m6", sd_m6, 0);
      chk("rst_sl_m6", sl_m6, 0); chk("rst_bz_m6", bz_m6, 0);
      chk("rst_rdy_m6", rdy_m6, 0); chk("rst_rdy_l6", rdy_l6, 0);
      chk("rst_sv8", sv8, 0); chk("rst_rdy8", rdy8, 0);
      rst = 1'b0;
      #1;
      chk("idle_rdy_m6", rdy_m6, 1); chk("idle_rdy8", rdy8, 1);

      // Single frames from idle on both 6-bit instances
      foreach (vecs[i]) begin
         d6 = vecs[i].word; v6 = 1'b1;
         #1;
         chk("t_rdy_pre", rdy_m6, 1);
         tick();
         v6 = 1'b0;
         for (int k = 0; k < FL6; k++) begin
            chk("t_sv_m6", sv_m6, 1);
            chk("t_bz_m6", bz_m6, 1);
            e = (k < 6) ? vecs[i].msb_seq[5-k] : vecs[i].par;
            chk("t_sd_m6", sd_m6, e);
            e = (k < 6) ? vecs[i].lsb_seq[5-k] : vecs[i].par;
            chk("t_sd_l6", sd_l6, e);
            chk("t_sl_m6", sl_m6, (k == FL6-1));
            chk("t_sl_l6", sl_l6, (k == FL6-1));
            chk("t_rdy_m6", rdy_m6, (k == FL6-1));
            tick();
         end
         chk("t_end_sv_m6", sv_m6, 0); chk("t_end_sv_l6", sv_l6, 0);
         chk("t_end_sd_m6", sd_m6, 0); chk("t_end_sl_m6", sl_m6, 0);
         chk("t_end_rdy_m6", rdy_m6, 1);
      end

      // Back-to-back 8'h2A then 8'h15 with valid held
      d8 = 8'h2A; v8 = 1'b1;
      tick();
      d8 = 8'h15;
      for (int k = 0; k < 2*FL8; k++) begin
         chk("b2b_sv", sv8, 1);
         chk("b2b_sd", sd8, exp8((k < FL8) ? 8'h2A : 8'h15, k % FL8));
         chk("b2b_sl", sl8, ((k % FL8) == FL8-1));
         chk("b2b_rdy", rdy8, ((k % FL8) == FL8-1));
         tick();
         if (k == FL8-1) v8 = 1'b0;
      end
      chk("b2b_end_sv", sv8, 0);

      // Stall: word offered mid-frame waits for the final bit
      d8 = 8'hC3; v8 = 1'b1;
      tick();
      v8 = 1'b0;
      for (int k = 0; k < FL8; k++) begin
         if (k == 2) begin d8 = 8'h5A; v8 = 1'b1; end
         chk("stall_rdy", rdy8, (k == FL8-1));
         chk("stall_sd1", sd8, exp8(8'hC3, k));
         tick();
      end
      v8 = 1'b0;
      for (int k = 0; k < FL8; k++) begin
         chk("stall_sv2", sv8, 1);
         chk("stall_sd2", sd8, exp8(8'h5A, k));
         chk("stall_sl2", sl8, (k == FL8-1));
         tick();
      end
      chk("stall_end_sv", sv8, 0);

      // Reset on the third bit of a frame, with valid raised during reset
      d8 = 8'hF0; v8 = 1'b1;
      tick();
      v8 = 1'b0;
      tick(); tick();
      chk("rmid_sd3", sd8, 1); chk("rmid_sv3", sv8, 1);
      rst = 1'b1; d8 = 8'hFF; v8 = 1'b1;
      #1;
      chk("rmid_rdy_in_rst", rdy8, 0);
      tick();
      chk("rmid_sv", sv8, 0); chk("rmid_sd", sd8, 0);
      chk("rmid_sl", sl8, 0); chk("rmid_bz", bz8, 0);
      rst = 1'b0; v8 = 1'b0;
      #1;
      chk("rmid_rdy_idle", rdy8, 1);
      tick();
      chk("rmid_no_frame", sv8, 0);
      d8 = 8'h81; v8 = 1'b1;
      tick();
      v8 = 1'b0;
      for (int k = 0; k < FL8; k++) begin
         chk("rpost_sv", sv8, 1);
         chk("rpost_sd", sd8, exp8(8'h81, k));
         chk("rpost_sl", sl8, (k == FL8-1));
         tick();
      end
      chk("rpost_end_sv", sv8, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/par_serializer.md
# par_serializer

Parametrised parallel-to-serial converter for outbound serial links. Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first. Supports back-to-back words with no idle gap and flags the final bit of each frame. Sits between word-oriented datapath logic and a single-wire serial output or line driver.

## Interface
- DATA_W, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit DATA_W-1 transmitted first; 0 = bit 0 transmitted first.

- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- data_i  input  DATA_W  parallel word; sampled when data_val_i && data_rdy_o.
- data_val_i  input  1  word valid; once raised, held with data_i stable until accepted.
- data_rdy_o  output  1  ready to accept a word (combinational from state and counter).
- ser_data_o  output  1  serial bit, registered; 0 when ser_val_o is low.
- ser_val_o  output  1  ser_data_o carries a frame bit, registered.
- ser_last_o  output  1  current bit is the final bit of the frame, registered.
- busy_o  output  1  frame in progress; equals ser_val_o.

## Operation
- States: IDLE, SHIFT.
- IDLE: data_rdy_o = 1. On accept, load the shift register with data_i, load the bit counter with FRAME_LEN-1, and go to SHIFT.
- SHIFT: each cycle presents the next bit: shift left and take bit DATA_W-1 if MSB_FIRST, else shift right and take bit 0. The counter decrements by 1 each cycle.
- Final bit (counter == 0): ser_last_o = 1 and data_rdy_o = 1.
  - If a word is accepted in this cycle, reload and stay in SHIFT. The next frame starts on the following cycle with no gap.
  - Otherwise return to IDLE.
- data_rdy_o is low in SHIFT whenever the counter is non-zero. Upstream stalls with data_i held.
- FRAME_LEN = DATA_W, or DATA_W+1 when parity is enabled.
- Counter width: $clog2(DATA_W+1). It must not wrap; counter == 0 is the only exit condition.
- Reset (rst_i = 1):
  - state = IDLE; shift register and counter cleared.
  - ser_data_o = 0, ser_val_o = 0, ser_last_o = 0, busy_o = 0.
  - data_rdy_o forced 0 while rst_i is high.
  - A frame in progress is abandoned with no partial completion. The first cycle after rst_i falls is IDLE.
- data_val_i asserted in the same cycle as rst_i is ignored.

## Timing
- Accept at clock edge N. The first bit appears on ser_data_o/ser_val_o after edge N (cycle N+1).
- The final bit is valid in cycle N+FRAME_LEN.
- Throughput: one word per FRAME_LEN cycles with continuous data_val_i. ser_val_o stays high continuously.
- From idle: ser_val_o goes low the cycle after the final bit when no new word is accepted.
- data_rdy_o depends on rst_i, state and counter only; it never depends on data_val_i.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - An even-parity bit (XOR of the accepted word) is appended after the data bits.
  - FRAME_LEN = DATA_W+1; ser_last_o marks the parity bit.
  - Parity is computed at accept time and stored.
- SERIALIZER_PARITY_EN undefined:
  - FRAME_LEN = DATA_W; no parity storage.

## Structure
- serializer_pkg holds:
  - ser_state_t enum (IDLE, SHIFT).
  - Function returning FRAME_LEN for a given DATA_W, honouring SERIALIZER_PARITY_EN.
  - Counter width constant/function.
- Single module; no sub-module. Shift register, counter and FSM are small enough to stay inline.

## Test plan
- DATA_W=6, MSB_FIRST=1, word 6'b101100 -> ser_data_o 1,0,1,1,0,0 in cycles N+1..N+6; ser_last_o only in N+6; ser_val_o low at N+7.
- DATA_W=6, MSB_FIRST=0, word 6'b101100 -> ser_data_o 0,0,1,1,0,1.
- Back-to-back, DATA_W=8: 8'h2A then 8'h15 with data_val_i held -> 16 contiguous ser_val_o cycles, bits 00101010 00010101; data_rdy_o high only on the two last-bit cycles after the first accept.
- Stall: data_val_i raised mid-frame -> data_rdy_o stays 0 until the last bit; word accepted exactly then; data_i changes before accept are a bench error (assertion).
- Reset at the third bit of a frame -> next cycle all outputs 0 and state IDLE; a word offered after reset is transmitted in full.
- SERIALIZER_PARITY_EN, DATA_W=6, word 6'b101100 -> 7-bit frame 1,0,1,1,0,0,1; ser_last_o on the parity bit.
